// File: rtl/muldiv_iter.sv
// Iterative RV32M multiply/divide unit.
// Multiplication uses radix-2 shift-add, and division uses restoring division.
// Both work on operand magnitudes, and the sign is fixed up at the end.
// Every operation takes 32 CALC cycles. The result is registered on the edge
// that enters DONE.
module muldiv_iter #(
  parameter int XLEN = 32
) (
  input  logic            iCLK,
  input  logic            iRSTn,
  input  logic            iStart,
  input  logic [2:0]      iFunct3,
  input  logic [XLEN-1:0] iA,
  input  logic [XLEN-1:0] iB,
  output logic            oBusy,
  output logic            oValid,
  output logic [XLEN-1:0] oResult
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [4:0]        cnt_q;
  logic [2:0]        funct_q;
  logic              sa_q, sb_q;
  logic              div0_q, ovf_q;
  logic [XLEN-1:0]   opnd_q;        // multiplicand (mul) or divisor (div)
  logic [2*XLEN-1:0] acc_q;         // {partial product | multiplier} or {remainder | dividend/quotient}
  logic              busy_q, valid_q;
  logic [XLEN-1:0]   result_q;

  logic              start_sa, start_sb;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift, div_diff;
  logic              qbit;
  logic [2*XLEN-1:0] acc_step;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot, rem;
  logic [XLEN-1:0]   result_d;

  // Decode the operand sign flags and magnitudes for the operation being started.
  always_comb begin
    start_sa = 1'b0;
    start_sb = 1'b0;
    case (iFunct3)
      3'b000, 3'b001, 3'b100, 3'b110: begin start_sa = 1'b1; start_sb = 1'b1; end
      3'b010:                         start_sa = 1'b1;
      default: ;
    endcase
    mag_a = (start_sa && iA[XLEN-1]) ? -iA : iA;
    mag_b = (start_sb && iB[XLEN-1]) ? -iB : iB;
  end

  // Compute one iteration step, then the signed result taken from the final step.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    qbit      = ~div_diff[XLEN];
    if (funct_q[2])
      acc_step = {(qbit ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]), acc_q[XLEN-2:0], qbit};
    else
      acc_step = {mul_sum, acc_q[XLEN-1:1]};

    prod = (sa_q ^ sb_q) ? -acc_step : acc_step;
    quot = (sa_q ^ sb_q) ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
    // With a zero divisor the remainder ends up as |iA|.
    // The sign fix-up then restores the original iA.
    rem  = sa_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];

    result_d = '0;
    case (funct_q)
      3'b000:                 result_d = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: result_d = prod[2*XLEN-1:XLEN];
      3'b100:                 result_d = div0_q ? '1 : (ovf_q ? {1'b1, {(XLEN-1){1'b0}}} : quot);
      3'b101:                 result_d = div0_q ? '1 : quot;
      3'b110:                 result_d = ovf_q ? '0 : rem;
      3'b111:                 result_d = rem;
      default: ;
    endcase
  end

  // Compute the next FSM state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (iStart) state_d = S_CALC;
      S_CALC:  if (cnt_q == 5'd31) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Register the FSM state, and the busy/valid flags derived from the next state.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != S_IDLE);
      valid_q <= (state_d == S_DONE);
    end
  end

  // Datapath: latch operands on start, iterate in CALC, and load the result on the last step.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      cnt_q    <= '0;
      funct_q  <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      if (state_q == S_IDLE && iStart) begin
        funct_q <= iFunct3;
        sa_q    <= start_sa && iA[XLEN-1];
        sb_q    <= start_sb && iB[XLEN-1];
        div0_q  <= (iB == '0);
        ovf_q   <= (iA == {1'b1, {(XLEN-1){1'b0}}}) && (iB == '1);
        opnd_q  <= iFunct3[2] ? mag_b : mag_a;
        acc_q   <= {{XLEN{1'b0}}, (iFunct3[2] ? mag_a : mag_b)};
        cnt_q   <= '0;
      end else if (state_q == S_CALC) begin
        acc_q <= acc_step;
        cnt_q <= cnt_q + 5'd1;
        if (cnt_q == 5'd31) result_q <= result_d;
      end
    end
  end

  assign oBusy   = busy_q;
  assign oValid  = valid_q;
  assign oResult = result_q;

endmodule
